// File: rtl/ring_johnson_counter.sv
// Ring / Johnson shift counter with direction control, parallel load and seed-wrap pulse.
// Define RJC_SELF_CORRECT_EN to build legality checking and self-correction on enabled steps.
module ring_johnson_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] RING_SEED = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] JOHN_SEED = '0;

    logic             mode_q;
    logic             mode_chg;
    logic             do_correct;
    logic             wrap_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] seed_cur;

    always_comb begin
        seed_cur = mode ? JOHN_SEED : RING_SEED;
        mode_chg = (mode != mode_q);
    end

    // One shift step; only used when mode == mode_q, so mode selects the feedback.
    always_comb begin
        step_val = q;
        unique case ({mode, dir})
            2'b00:   step_val = {q[0], q[WIDTH-1:1]};
            2'b01:   step_val = {q[WIDTH-2:0], q[WIDTH-1]};
            2'b10:   step_val = {~q[0], q[WIDTH-1:1]};
            2'b11:   step_val = {q[WIDTH-2:0], ~q[WIDTH-1]};
            default: step_val = q;
        endcase
    end

`ifdef RJC_SELF_CORRECT_EN
    logic [WIDTH-1:0] q_inv;
    logic [WIDTH-1:0] low_run_chk;
    logic [WIDTH-1:0] high_run_chk;
    logic             ring_ok;
    logic             john_ok;

    // Johnson-legal: set bits are a run from bit 0 (q & (q+1) == 0) or from the MSB (same test on ~q).
    always_comb begin
        q_inv        = ~q;
        low_run_chk  = q & (q + WIDTH'(1));
        high_run_chk = q_inv & (q_inv + WIDTH'(1));
        ring_ok      = $onehot(q);
        john_ok      = (low_run_chk == '0) || (high_run_chk == '0);
        err          = mode_q ? !john_ok : !ring_ok;
        do_correct   = err;
    end
`else
    always_comb begin
        err        = 1'b0;
        do_correct = 1'b0;
    end
`endif

    // Priority: load > mode change > enabled step (or correction) > hold.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = load_val;
        end else if (mode_chg) begin
            q_next = seed_cur;
        end else if (en) begin
            if (do_correct) begin
                q_next = seed_cur;
            end else begin
                q_next    = step_val;
                wrap_next = (step_val == seed_cur);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= RING_SEED;
            mode_q <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            q      <= q_next;
            mode_q <= mode;
            wrap   <= wrap_next;
        end
    end

endmodule

// File: doc/ring_johnson_counter.md
RING_JOHNSON_COUNTER -- requirements
Module: ring_johnson_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  count enable; one step per enabled rising edge.
REQ-005 mode  input  1  0 = ring (one-hot rotate), 1 = Johnson (twisted-ring).
REQ-006 dir  input  1  0 = shift right (toward bit 0), 1 = shift left (toward bit WIDTH-1).
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  WIDTH  value loaded into q when load=1.
REQ-009 q  output  WIDTH  counter state, registered.
REQ-010 wrap  output  1  registered one-cycle pulse; sequence returned to its seed.
REQ-011 err  output  1  combinational flag; q is not a legal pattern for the current mode.

Function
REQ-012 Seeds: ring seed = bit WIDTH-1 set, all other bits 0; Johnson seed = all zeros.
REQ-013 Ring right step: q[WIDTH-1] <= q[0], q[i] <= q[i+1]; ring left step: q[0] <= q[WIDTH-1], q[i+1] <= q[i].
REQ-014 Johnson right step: q[WIDTH-1] <= ~q[0], q[i] <= q[i+1]; Johnson left step: q[0] <= ~q[WIDTH-1], q[i+1] <= q[i].
REQ-015 Period: WIDTH steps in ring mode, 2*WIDTH steps in Johnson mode, either direction.
REQ-016 Internal register mode_q holds the mode of the previous cycle; a mode change is mode != mode_q.
REQ-017 Per-edge priority: load > mode change > en > hold.
REQ-018 load=1: q <= load_val unchecked; en, dir, mode change ignored; mode_q <= mode.
REQ-019 load=0 and mode change: q <= seed of new mode, regardless of en; mode_q <= mode.
REQ-020 en=0 and no load and no mode change: q holds.
REQ-021 dir may change on any cycle; takes effect on the same edge with no reload.
REQ-022 wrap <= 1 only on an edge where a shift step (REQ-013/014) produces the seed of the current mode; wrap <= 0 on every other edge, including load, mode-change reload, correction and hold.
REQ-023 Ring legality: exactly one bit of q set.
REQ-024 Johnson legality: set bits form one contiguous run touching bit WIDTH-1 or bit 0; all-zeros and all-ones are legal.
REQ-025 err = 1 while q is illegal for mode_q; err is 0 otherwise (subject to REQ-031).

Reset
REQ-026 rst_n=0 forces, asynchronously: q = ring seed, mode_q = 0, wrap = 0.
REQ-027 Reset asserted mid-sequence takes effect immediately, without waiting for a clock edge; wrap does not pulse.
REQ-028 After release with mode=1, the first edge performs a mode-change reload to all zeros (REQ-019).
REQ-029 Deassertion is glitch-free: no count on an edge coincident with release.

Configuration
REQ-030 Macro RJC_SELF_CORRECT_EN defined: an enabled step (en=1, no load, no mode change) with err=1 loads the current mode's seed instead of shifting; wrap=0 on that edge.
REQ-031 Macro RJC_SELF_CORRECT_EN undefined: no legality logic is built; illegal patterns shift per REQ-013/014; err is tied to 0.

Verification (WIDTH=4)
REQ-032 Reset, mode=0, dir=0, en=1 -> q: 1000, 0100, 0010, 0001, 1000; wrap=1 only in the cycle after the 4th edge.
REQ-033 Reset, mode=1, dir=0, en=1 -> edge 1 gives 0000 (reload, wrap=0); then 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; wrap=1 after the 0000 step only.
REQ-034 Ring, q=1000, dir=1, en=1 -> 0001, 0010, 0100; toggle dir=0 while q=0100 -> 0010.
REQ-035 load=1, load_val=0110, mode=0 -> q=0110 and err=1; next edge with en=1: macro on -> q=1000, wrap=0, err=0; macro off -> q=0011, err=0.
REQ-036 load=1 and en=1 together with load_val=0010 -> q=0010, wrap=0; en=0 for 3 edges -> q stays 0010.
REQ-037 Ring counting at q=0010, pulse rst_n low between edges -> q=1000 before the next edge, wrap=0; counting resumes 0100 after release.
